// File: rtl/tcam_lookup_seq.sv
// Command sequencer in front of a TCAM controller: entry writes/invalidates, table flush, packet lookups.
// Latency: write/flush 2 cycles; lookup result valid LOOKUP_LAT+2 cycles after pkt accept.
// Backpressure: single result buffer, held until res_ready; new lookups stall while a result is pending.
// Optional build macro TCAM_SEQ_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module tcam_lookup_seq #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int LOOKUP_LAT  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ent_valid,
    output logic                     ent_ready,
    input  logic [AddressSize-1:0]   ent_addr,
    input  logic [ID_Width-1:0]      ent_key,
    input  logic [ID_Width-1:0]      ent_kmask,
    input  logic [ID_Width-1:0]      ent_dst,
    input  logic                     ent_vld,
    input  logic                     flush_req,
    output logic                     flush_done,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic [ID_Width-1:0]      pkt_id,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_Width-1:0]      res_dst,
    output logic                     res_miss,
`ifdef TCAM_SEQ_STATS_EN
    output logic [15:0]              hit_cnt,
    output logic [15:0]              miss_cnt,
`endif
    output logic [2:0]               MODE,
    output logic [ID_Width-1:0]      PacketID_Out,
    output logic                     Vbe_Out,
    output logic                     Dcs_Out,
    output logic                     Vbi_Out,
    output logic [2*ID_Width-1:0]    Data_Out,
    output logic [2*ID_Width-1:0]    Mskb_Out,
    output logic [AddressSize-1:0]   A_Out,
    input  logic [ID_Width-1:0]      DstID_In
);

    localparam logic [2:0] MODE_I   = 3'b000;
    localparam logic [2:0] MODE_W   = 3'b001;
    localparam logic [2:0] MODE_F   = 3'b011;
    localparam logic [2:0] MODE_C   = 3'b100;
    localparam logic [2:0] MODE_RST = 3'b101;

    // Wait counter runs 0..LOOKUP_LAT inclusive, so it needs room for LOOKUP_LAT itself.
    localparam int            CW       = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(LOOKUP_LAT);

    typedef enum logic [3:0] {
        ST_RST,
        ST_IDLE,
        ST_FL_ISS,
        ST_FL_HOLD,
        ST_WR_ISS,
        ST_WR_HOLD,
        ST_LK_ISS,
        ST_LK_WAIT,
        ST_LK_RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Single sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_RST;
            cnt          <= '0;
            MODE         <= MODE_RST;
            ent_ready    <= 1'b0;
            pkt_ready    <= 1'b0;
            flush_done   <= 1'b0;
            res_valid    <= 1'b0;
            res_dst      <= '0;
            res_miss     <= 1'b0;
            PacketID_Out <= '0;
            Vbe_Out      <= 1'b0;
            Dcs_Out      <= 1'b0;
            Vbi_Out      <= 1'b0;
            Data_Out     <= '0;
            Mskb_Out     <= '0;
            A_Out        <= '0;
`ifdef TCAM_SEQ_STATS_EN
            hit_cnt      <= '0;
            miss_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_RST: begin
                    MODE  <= MODE_I;
                    state <= ST_IDLE;
                end

                ST_IDLE: begin
                    MODE       <= MODE_I;
                    Vbe_Out    <= 1'b0;
                    Dcs_Out    <= 1'b0;
                    Vbi_Out    <= 1'b0;
                    ent_ready  <= 1'b0;
                    pkt_ready  <= 1'b0;
                    flush_done <= 1'b0;
                    if (flush_req) begin
                        MODE  <= MODE_F;
                        state <= ST_FL_ISS;
                    end else if (ent_valid) begin
                        // Requester holds the entry stable until ent_ready, so load it now.
                        MODE      <= MODE_W;
                        ent_ready <= 1'b1;
                        Vbe_Out   <= 1'b1;
                        Dcs_Out   <= 1'b1;
                        Vbi_Out   <= ent_vld;
                        Data_Out  <= {ent_key, ent_dst};
                        Mskb_Out  <= {ent_kmask, {ID_Width{1'b1}}};
                        A_Out     <= ent_addr;
                        state     <= ST_WR_ISS;
                    end else if (pkt_valid && !res_valid) begin
                        MODE         <= MODE_C;
                        pkt_ready    <= 1'b1;
                        PacketID_Out <= pkt_id;
                        state        <= ST_LK_ISS;
                    end
                end

                ST_FL_ISS: begin
                    MODE       <= MODE_I;
                    flush_done <= 1'b1;
                    state      <= ST_FL_HOLD;
                end

                ST_FL_HOLD: begin
                    flush_done <= 1'b0;
                    state      <= ST_IDLE;
                end

                ST_WR_ISS: begin
                    // Controller consumes Data/Mskb/A/Vbi during the hold cycle; keep them put.
                    MODE      <= MODE_I;
                    ent_ready <= 1'b0;
                    state     <= ST_WR_HOLD;
                end

                ST_WR_HOLD: begin
                    Vbe_Out <= 1'b0;
                    Dcs_Out <= 1'b0;
                    Vbi_Out <= 1'b0;
                    state   <= ST_IDLE;
                end

                ST_LK_ISS: begin
                    MODE      <= MODE_I;
                    pkt_ready <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_LK_WAIT;
                end

                ST_LK_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        res_dst   <= DstID_In;
                        res_miss  <= (DstID_In == '0);
                        res_valid <= 1'b1;
                        state     <= ST_LK_RESP;
`ifdef TCAM_SEQ_STATS_EN
                        if (DstID_In == '0) begin
                            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                        end else begin
                            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                        end
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_LK_RESP: begin
                    // Pending flush/entry requests wait here; a lookup is never abandoned.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    MODE  <= MODE_I;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_lookup_seq.sv
module tb_tcam_lookup_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ent_valid, ent_ready, ent_vld;
    logic [3:0] ent_addr, ent_key, ent_kmask, ent_dst;
    logic       flush_req, flush_done;
    logic       pkt_valid, pkt_ready;
    logic [3:0] pkt_id;
    logic       res_valid, res_ready, res_miss;
    logic [3:0] res_dst;
    logic [2:0] MODE;
    logic [3:0] PacketID_Out;
    logic       Vbe_Out, Dcs_Out, Vbi_Out;
    logic [7:0] Data_Out, Mskb_Out;
    logic [3:0] A_Out;
    logic [3:0] DstID_In;
`ifdef TCAM_SEQ_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tcam_lookup_seq #(.ID_Width(4), .AddressSize(4), .LOOKUP_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_addr(ent_addr),
        .ent_key(ent_key), .ent_kmask(ent_kmask), .ent_dst(ent_dst), .ent_vld(ent_vld),
        .flush_req(flush_req), .flush_done(flush_done),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_id(pkt_id),
        .res_valid(res_valid), .res_ready(res_ready), .res_dst(res_dst), .res_miss(res_miss),
`ifdef TCAM_SEQ_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .MODE(MODE), .PacketID_Out(PacketID_Out),
        .Vbe_Out(Vbe_Out), .Dcs_Out(Dcs_Out), .Vbi_Out(Vbi_Out),
        .Data_Out(Data_Out), .Mskb_Out(Mskb_Out), .A_Out(A_Out),
        .DstID_In(DstID_In)
    );

    // Behavioural TCAM controller: Mskb bit 1 = don't care, lowest valid address wins,
    // DstID valid only in the fourth cycle after the cycle MODE=C is presented.
    logic       m_v [16];
    logic [3:0] m_key [16];
    logic [3:0] m_kmask [16];
    logic [3:0] m_dst [16];
    logic [3:0] d0 = '0, d1 = '0, d2 = '0;

    function automatic logic [3:0] model_lookup(input logic [3:0] pid);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--)
            if (m_v[i] && (((m_key[i] ^ pid) & ~m_kmask[i]) == 4'h0)) r = m_dst[i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (MODE == 3'b101 || MODE == 3'b011) begin
            for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
        end
        if (MODE == 3'b001 && Vbe_Out && Dcs_Out) begin
            m_v[A_Out]     <= Vbi_Out;
            m_key[A_Out]   <= Data_Out[7:4];
            m_dst[A_Out]   <= Data_Out[3:0];
            m_kmask[A_Out] <= Mskb_Out[7:4];
        end
        d0       <= (MODE == 3'b100) ? model_lookup(PacketID_Out) : 4'h0;
        d1       <= d0;
        d2       <= d1;
        DstID_In <= d2;
    end

    // Command monitor: count compare issues and any back-to-back C/W/F commands.
    int         c_issues = 0;
    int         b2b_viol = 0;
    logic [2:0] prev_mode = 3'b000;
    function automatic bit is_cmd(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b011) || (m == 3'b100);
    endfunction
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (MODE == 3'b100) c_issues++;
            if (is_cmd(MODE) && is_cmd(prev_mode)) b2b_viol++;
        end
        prev_mode = MODE;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full lookup handshake; returns sampled result and cycles from accept to res_valid.
    task automatic do_lookup(input logic [3:0] pid, output logic [3:0] dst,
                             output logic miss, output int lat);
        bit got;
        pkt_valid = 1'b1;
        pkt_id    = pid;
        got = 0;
        lat = -1;
        dst = 'x;
        miss = 1'bx;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (pkt_ready) got = 1;
        end
        if (got) begin
            got = 0;
            for (int i = 1; i <= 30 && !got; i++) begin
                tick();
                pkt_valid = 1'b0;
                if (res_valid) begin
                    got = 1;
                    lat = i;
                end
            end
        end
        pkt_valid = 1'b0;
        if (got) begin
            dst  = res_dst;
            miss = res_miss;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (MODE !== 3'b101) begin
            tests_failed++;
            $display("FAIL reset_mode: got %b expected 101", MODE);
        end
        tests_run++;
        if ({res_valid, ent_ready, pkt_ready, flush_done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {res_valid, ent_ready, pkt_ready, flush_done});
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (MODE !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_release_mode: got %b expected 000", MODE);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] k, input logic [3:0] km,
                            input logic [3:0] d, input logic v);
        ent_valid = 1'b1;
        ent_addr = a; ent_key = k; ent_kmask = km; ent_dst = d; ent_vld = v;
        for (int i = 0; i < 20 && !ent_ready; i++) tick();
        tick();
        ent_valid = 1'b0;
        tick();
    endtask

    task automatic test_write;
        ent_valid = 1'b1;
        ent_addr = 4'd3; ent_key = 4'hA; ent_kmask = 4'h0; ent_dst = 4'h5; ent_vld = 1'b1;
        tick();
        tests_run++;
        if ({MODE, ent_ready, Vbe_Out, Dcs_Out, Vbi_Out} !== 7'b001_1111) begin
            tests_failed++;
            $display("FAIL write_issue: got mode=%b rdy/vbe/dcs/vbi=%b expected 001 1111",
                     MODE, {ent_ready, Vbe_Out, Dcs_Out, Vbi_Out});
        end
        tests_run++;
        if ({Data_Out, Mskb_Out, A_Out} !== {8'hA5, 8'h0F, 4'd3}) begin
            tests_failed++;
            $display("FAIL write_fields: got data=%h mskb=%h a=%h expected a5 0f 3",
                     Data_Out, Mskb_Out, A_Out);
        end
        tick();
        ent_valid = 1'b0;
        tests_run++;
        if ({MODE, ent_ready, Vbi_Out, Data_Out, Mskb_Out, A_Out} !== {3'b000, 1'b0, 1'b1, 8'hA5, 8'h0F, 4'd3}) begin
            tests_failed++;
            $display("FAIL write_hold: got mode=%b rdy=%b vbi=%b data=%h mskb=%h a=%h expected 000 0 1 a5 0f 3",
                     MODE, ent_ready, Vbi_Out, Data_Out, Mskb_Out, A_Out);
        end
        tick();
        tests_run++;
        if ({MODE, Vbe_Out, Dcs_Out, Vbi_Out, Data_Out} !== {3'b000, 3'b000, 8'hA5}) begin
            tests_failed++;
            $display("FAIL write_idle: got mode=%b en=%b data=%h expected 000 000 a5",
                     MODE, {Vbe_Out, Dcs_Out, Vbi_Out}, Data_Out);
        end
    endtask

    task automatic test_lookup_hit;
        logic [3:0] dst; logic miss; int lat; int c0;
        c0 = c_issues;
        do_lookup(4'hA, dst, miss, lat);
        tests_run++;
        if (lat != 5) begin
            tests_failed++;
            $display("FAIL hit_latency: got %0d cycles expected 5", lat);
        end
        tests_run++;
        if ({dst, miss} !== {4'h5, 1'b0}) begin
            tests_failed++;
            $display("FAIL hit_result: got dst=%h miss=%b expected 5 0", dst, miss);
        end
        tests_run++;
        if (c_issues - c0 != 1) begin
            tests_failed++;
            $display("FAIL hit_single_issue: got %0d compare cycles expected 1", c_issues - c0);
        end
    endtask

    task automatic test_miss_hold;
        bit got; int bad;
        pkt_valid = 1'b1;
        pkt_id = 4'h7;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (res_valid) got = 1;
        end
        tests_run++;
        if (!got || {res_dst, res_miss} !== {4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL miss_result: got valid=%b dst=%h miss=%b expected 1 0 1",
                     got, res_dst, res_miss);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({res_valid, res_dst, res_miss, pkt_ready} !== {1'b1, 4'h0, 1'b1, 1'b0}) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL miss_hold: got %0d bad cycles of 5 expected 0", bad);
        end
        pkt_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        tests_run++;
        if ({res_valid, MODE} !== 4'b0_000) begin
            tests_failed++;
            $display("FAIL miss_drain: got valid=%b mode=%b expected 0 000", res_valid, MODE);
        end
`ifdef TCAM_SEQ_STATS_EN
        tests_run++;
        if ({hit_cnt, miss_cnt} !== {16'd1, 16'd1}) begin
            tests_failed++;
            $display("FAIL stats_counts: got hit=%0d miss=%0d expected 1 1", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_flush_priority;
        logic [3:0] dst; logic miss; int lat;
        flush_req = 1'b1;
        pkt_valid = 1'b1;
        pkt_id = 4'hA;
        tick();
        tests_run++;
        if ({MODE, pkt_ready} !== 4'b011_0) begin
            tests_failed++;
            $display("FAIL flush_first: got mode=%b pkt_ready=%b expected 011 0", MODE, pkt_ready);
        end
        tick();
        tests_run++;
        if ({MODE, flush_done} !== 4'b000_1) begin
            tests_failed++;
            $display("FAIL flush_done: got mode=%b done=%b expected 000 1", MODE, flush_done);
        end
        flush_req = 1'b0;
        do_lookup(4'hA, dst, miss, lat);
        tests_run++;
        if ({dst, miss} !== {4'h0, 1'b1} || lat != 5) begin
            tests_failed++;
            $display("FAIL flush_then_lookup: got dst=%h miss=%b lat=%0d expected 0 1 5", dst, miss, lat);
        end
    endtask

    task automatic test_mask_invalidate;
        logic [3:0] dst; logic miss; int lat;
        do_write(4'd6, 4'h8, 4'h3, 4'h9, 1'b1);
        do_lookup(4'hB, dst, miss, lat);
        tests_run++;
        if ({dst, miss} !== {4'h9, 1'b0}) begin
            tests_failed++;
            $display("FAIL masked_hit: got dst=%h miss=%b expected 9 0", dst, miss);
        end
        do_lookup(4'h4, dst, miss, lat);
        tests_run++;
        if ({dst, miss} !== {4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL masked_miss: got dst=%h miss=%b expected 0 1", dst, miss);
        end
        do_write(4'd6, 4'h8, 4'h3, 4'h9, 1'b0);
        do_lookup(4'hB, dst, miss, lat);
        tests_run++;
        if ({dst, miss} !== {4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL invalidate: got dst=%h miss=%b expected 0 1", dst, miss);
        end
    endtask

    task automatic test_back_to_back;
        tests_run++;
        if (b2b_viol != 0) begin
            tests_failed++;
            $display("FAIL back_to_back_cmds: got %0d expected 0", b2b_viol);
        end
    endtask

    task automatic test_reset_mid_lookup;
        bit got; int seen;
        do_write(4'd1, 4'h2, 4'h0, 4'h6, 1'b1);
        pkt_valid = 1'b1;
        pkt_id = 4'h2;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (pkt_ready) got = 1;
        end
        tick();
        pkt_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({MODE, res_valid, pkt_ready} !== 5'b101_0_0) begin
            tests_failed++;
            $display("FAIL midreset_state: got mode=%b valid=%b rdy=%b expected 101 0 0",
                     MODE, res_valid, pkt_ready);
        end
`ifdef TCAM_SEQ_STATS_EN
        tests_run++;
        if ({hit_cnt, miss_cnt} !== 32'd0) begin
            tests_failed++;
            $display("FAIL stats_reset: got hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
        end
`endif
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (MODE !== 3'b000) begin
            tests_failed++;
            $display("FAIL midreset_release: got mode=%b expected 000", MODE);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL midreset_no_result: got %0d valid cycles expected 0", seen);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ent_valid = 1'b0; ent_addr = '0; ent_key = '0; ent_kmask = '0; ent_dst = '0; ent_vld = 1'b0;
        flush_req = 1'b0; pkt_valid = 1'b0; pkt_id = '0; res_ready = 1'b0;
        test_reset();
        test_write();
        test_lookup_hit();
        test_miss_hold();
        test_flush_priority();
        test_mask_invalidate();
        test_back_to_back();
        test_reset_mid_lookup();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
